// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package arm_mem_pkg;

    localparam int unsigned BASE_ADDR_DEF = 1024;
    localparam int unsigned SRAM_AW_DEF   = 18;
    localparam int unsigned SRAM_DW       = 16;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StWrLo,
        StWrHi,
        StDone
    } mem_state_t;

    function automatic logic is_phase(input mem_state_t s);
        return s inside {StRdLo, StRdHi, StWrLo, StWrHi};
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half-access phase counter: counts 0..SRAM_WAIT-1 while enabled, flags the last cycle.
module sram_wait_counter
    import arm_mem_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SRAM_WAIT - 1);

    assign last = enable && (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: 32-bit loads/stores split into two 16-bit SRAM accesses,
// stalling the front of the pipeline while an access is in flight.
module mem_stage_sram_ctrl
    import arm_mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned SRAM_WAIT = 2,
    parameter int unsigned SRAM_AW   = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read_en,
    input  logic               mem_write_en,
    input  logic [WORD_W-1:0]  alu_result,
    input  logic [WORD_W-1:0]  st_val,
    output logic [WORD_W-1:0]  mem_result,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in
);

    // Cycle before the last of a phase: strobe must rise so the last cycle holds data/addr.
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SRAM_WAIT - 2);

    mem_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               in_phase;
    logic [SRAM_AW-2:0] word_addr;
    logic [SRAM_DW-1:0] st_hi;

    // Addresses below BASE_ADDR wrap modulo 2^32 before truncation.
    assign word_addr = (SRAM_AW - 1)'((alu_result - BASE_ADDR) >> 2);
    assign in_phase  = is_phase(state);
    assign ready     = ((state == StIdle) && !mem_read_en && !mem_write_en) || (state == StDone);

    sram_wait_counter #(
        .SRAM_WAIT (SRAM_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (last),
        .enable (in_phase),
        .cnt    (cnt),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            mem_result  <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            st_hi       <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (mem_write_en) begin
                        state       <= StWrLo;
                        sram_addr   <= {word_addr, 1'b0};
                        sram_dq_out <= st_val[15:0];
                        st_hi       <= st_val[31:16];
                        sram_dq_oe  <= 1'b1;
                        sram_we_n   <= 1'b0;
                    end else if (mem_read_en) begin
                        state     <= StRdLo;
                        sram_addr <= {word_addr, 1'b0};
                    end
                end
                StRdLo: begin
                    if (last) begin
                        mem_result[15:0] <= sram_dq_in;
                        sram_addr[0]     <= 1'b1;
                        state            <= StRdHi;
                    end
                end
                StRdHi: begin
                    if (last) begin
                        mem_result[31:16] <= sram_dq_in;
                        state             <= StDone;
                    end
                end
                StWrLo: begin
                    if (last) begin
                        sram_addr[0] <= 1'b1;
                        sram_dq_out  <= st_hi;
                        sram_we_n    <= 1'b0;
                        state        <= StWrHi;
                    end else begin
                        sram_we_n <= (cnt == PRE_LAST);
                    end
                end
                StWrHi: begin
                    if (last) begin
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        state      <= StDone;
                    end else begin
                        sram_we_n <= (cnt == PRE_LAST);
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench: randomized loads/stores against a word-level memory model and SRAM model.
module tb_mem_stage_sram_ctrl;

    localparam int unsigned W    = 2;
    localparam int unsigned W4   = 4;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_read_en, mem_write_en;
    logic [31:0] alu_result, st_val, mem_result;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_dq_oe;
    logic [15:0] sram_dq_out, sram_dq_in;

    logic        rd4, wr4;
    logic [31:0] addr4, st4, mem_result4;
    logic        ready4;
    logic [17:0] sram_addr4;
    logic        sram_we_n4, sram_dq_oe4;
    logic [15:0] sram_dq_out4, sram_dq_in4;

    mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_WAIT(W), .SRAM_AW(18)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .alu_result   (alu_result),
        .st_val       (st_val),
        .mem_result   (mem_result),
        .ready        (ready),
        .sram_addr    (sram_addr),
        .sram_we_n    (sram_we_n),
        .sram_dq_out  (sram_dq_out),
        .sram_dq_oe   (sram_dq_oe),
        .sram_dq_in   (sram_dq_in)
    );

    mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_WAIT(W4), .SRAM_AW(18)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .mem_read_en  (rd4),
        .mem_write_en (wr4),
        .alu_result   (addr4),
        .st_val       (st4),
        .mem_result   (mem_result4),
        .ready        (ready4),
        .sram_addr    (sram_addr4),
        .sram_we_n    (sram_we_n4),
        .sram_dq_out  (sram_dq_out4),
        .sram_dq_oe   (sram_dq_oe4),
        .sram_dq_in   (sram_dq_in4)
    );

    // Unwritten SRAM locations read back a fixed per-address pattern.
    function automatic logic [15:0] init_f(input logic [17:0] a);
        if (a == 18'd2) return 16'h1234;
        if (a == 18'd3) return 16'hABCD;
        return 16'(a * 18'h09E37) ^ 16'hC3A5;
    endfunction

    logic [15:0] sram_mem     [0:262143];
    bit          sram_written [0:262143];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr]     <= sram_dq_out;
            sram_written[sram_addr] <= 1'b1;
        end
    end

    always_comb sram_dq_in = sram_written[sram_addr] ? sram_mem[sram_addr] : init_f(sram_addr);
    assign sram_dq_in4 = init_f(sram_addr4);

    function automatic logic [15:0] sram_peek(input logic [17:0] a);
        return sram_written[a] ? sram_mem[a] : init_f(a);
    endfunction

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_words [int];
    logic [31:0] exp_result;

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] word_expect(input int w);
        if (ref_words.exists(w)) return ref_words[w];
        return {init_f(18'(2 * w + 1)), init_f(18'(2 * w))};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
        int w, n, wlow, oecnt;
        bit done;
        w = widx(addr);
        @(negedge clk);
        mem_read_en  = rd;
        mem_write_en = wr;
        alu_result   = addr;
        st_val       = data;
        #1 check({tag, " req_ready"}, 32'(ready), 32'(!(rd || wr)));
        n = 0; wlow = 0; oecnt = 0; done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (ready) begin
                done = 1'b1;
            end else begin
                if (!sram_we_n) wlow++;
                if (sram_dq_oe) oecnt++;
                alu_result = $urandom;
                st_val     = $urandom;
            end
        end
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        if (wr) ref_words[w] = data;
        else if (rd) exp_result = word_expect(w);
        check({tag, " stall"}, 32'(n), 32'(2 * W + 1));
        check({tag, " mem_result"}, mem_result, exp_result);
        check({tag, " we_cycles"}, 32'(wlow), wr ? 32'(2 * (W - 1)) : 32'd0);
        check({tag, " oe_cycles"}, 32'(oecnt), wr ? 32'(2 * W) : 32'd0);
        if (wr) check({tag, " sram_word"},
                      {sram_peek(18'(2 * w + 1)), sram_peek(18'(2 * w))}, data);
    endtask

    task automatic access4(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input string tag);
        int w, n;
        bit done;
        logic [7:0]  pat;
        logic [17:0] a1, a5;
        logic [15:0] d1, d5;
        w = widx(addr);
        pat = '0; a1 = '0; a5 = '0; d1 = '0; d5 = '0;
        @(negedge clk);
        rd4 = rd; wr4 = wr; addr4 = addr; st4 = data;
        n = 0; done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (ready4) begin
                done = 1'b1;
            end else begin
                pat = {pat[6:0], sram_we_n4};
                if (n == 1) begin a1 = sram_addr4; d1 = sram_dq_out4; end
                if (n == 5) begin a5 = sram_addr4; d5 = sram_dq_out4; end
            end
        end
        rd4 = 1'b0; wr4 = 1'b0;
        check({tag, " stall"}, 32'(n), 32'(2 * W4 + 1));
        if (wr) begin
            check({tag, " we_pattern"}, 32'(pat), 32'h11);
            check({tag, " addr_lo"}, 32'(a1), 32'(2 * w));
            check({tag, " addr_hi"}, 32'(a5), 32'(2 * w + 1));
            check({tag, " dq_lo"}, 32'(d1), 32'(data[15:0]));
            check({tag, " dq_hi"}, 32'(d5), 32'(data[31:16]));
        end else begin
            check({tag, " we_pattern"}, 32'(pat), 32'hFF);
            check({tag, " mem_result"}, mem_result4,
                  {init_f(18'(2 * w + 1)), init_f(18'(2 * w))});
        end
    endtask

    initial begin
        int op;
        logic [31:0] a;
        rst = 1'b1;
        mem_read_en = 1'b0; mem_write_en = 1'b0; alu_result = '0; st_val = '0;
        rd4 = 1'b0; wr4 = 1'b0; addr4 = '0; st4 = '0;
        exp_result = '0;
        #2;
        check("reset ready", 32'(ready), 32'd1);
        check("reset we_n", 32'(sram_we_n), 32'd1);
        check("reset oe", 32'(sram_dq_oe), 32'd0);
        check("reset addr", 32'(sram_addr), 32'd0);
        check("reset mem_result", mem_result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "st_1024");
        check("st_1024 half0", 32'(sram_peek(18'd0)), 32'h0000BEEF);
        check("st_1024 half1", 32'(sram_peek(18'd1)), 32'h0000DEAD);
        access(1'b1, 1'b0, 32'd1028, 32'h0, "ld_1028");
        check("ld_1028 value", mem_result, 32'hABCD1234);
        access(1'b1, 1'b1, 32'd1032, 32'h0BADF00D, "rdwr_1032");
        check("rdwr_1032 half4", 32'(sram_peek(18'd4)), 32'h0000F00D);

        access(1'b1, 1'b0, 32'd1024, 32'h0, "b2b_ld0");
        access(1'b0, 1'b1, 32'd1036, 32'h5A5AC3C3, "b2b_st");
        access(1'b1, 1'b0, 32'd1036, 32'h0, "b2b_ld1");

        access(1'b0, 1'b1, 32'd1020, 32'h13579BDF, "wrap_st");
        check("wrap_st addr", 32'(sram_peek(18'h3FFFE)), 32'h00009BDF);
        access(1'b1, 1'b0, 32'd1020, 32'h0, "wrap_ld");

        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 2));
            a  = BASE + 32'(4 * $urandom_range(0, 15));
            access(op != 1, op != 0, a, $urandom, "rand");
        end

        // Reset in the middle of the low-half write.
        @(negedge clk);
        mem_write_en = 1'b1; alu_result = 32'd1064; st_val = $urandom;
        @(negedge clk);
        check("rstmid pre_we_n", 32'(sram_we_n), 32'd0);
        mem_write_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid we_n", 32'(sram_we_n), 32'd1);
        check("rstmid oe", 32'(sram_dq_oe), 32'd0);
        check("rstmid ready", 32'(ready), 32'd1);
        check("rstmid mem_result", mem_result, 32'd0);
        exp_result = '0;
        @(negedge clk);
        rst = 1'b0;
        access(1'b1, 1'b0, 32'd1028, 32'h0, "post_rst_ld");

        access4(1'b1, 1'b0, 32'd1052, 32'h0, "w4_ld");
        access4(1'b0, 1'b1, 32'd1060, $urandom, "w4_st");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
